// File: rtl/onn_phase_scan_ctrl.sv
// onn_phase_scan_ctrl: scan scheduler for the 3x5 oscillatory neural network.
// One phase-read mux is time-shared across all N neurons. Each phase is
// binarised against the reference oscillator and the N-bit state is compared
// with the previous iteration to produce state_changed, convergence and
// timeout indications.
//
// Optional feature: define PHASE_HYST_EN to add a hysteresis band of HYST LSBs
// around both decision boundaries. Inside the band a neuron keeps its
// previous bit. With the macro undefined the decision is a plain quadrant
// threshold with no memory.
//
// Handshake: start is a level sampled only while IDLE; one accepted start
// runs exactly one scan. start during busy is dropped, never queued.
// scan_done is a one-cycle pulse in the cycle after UPD, and state_vec,
// state_changed, iter_cnt, converged and timeout become valid together
// with it. clr has priority over start and aborts any scan in flight.
module onn_phase_scan_ctrl #(
  parameter int N        = 15,
  parameter int PW       = 8,
  parameter int RD_LAT   = 1,
  parameter int STABLE_N = 3,
  parameter int MAX_ITER = 255,
  parameter int HYST     = 8
) (
  input  logic          sclk,
  input  logic          re_n,
  input  logic          start,
  input  logic          clr,
  input  logic [PW-1:0] ref_phase,
  input  logic [PW-1:0] phase_in,
  output logic [3:0]    phase_sel,
  output logic          busy,
  output logic [N-1:0]  state_vec,
  output logic [N-1:0]  state_changed,
  output logic          scan_done,
  output logic          converged,
  output logic          timeout,
  output logic [7:0]    iter_cnt,
  output logic [1:0]    dbg_state
);

  // Scan counter runs 0..N+RD_LAT-1: N selects plus the read-pipeline drain.
  localparam int LAST = N + RD_LAT - 1;
  localparam int CW   = $clog2(LAST + 1);
  localparam int IW   = $clog2(N);

  localparam logic [CW-1:0] C_LAST = CW'(LAST);
  localparam logic [CW-1:0] C_LAT  = CW'(RD_LAT);
  localparam logic [CW-1:0] C_NSEL = CW'(N);

  // Quadrant boundaries of the phase difference, one extra bit of headroom.
  localparam logic [PW:0] B_LO = (PW+1)'(2**(PW-2));
  localparam logic [PW:0] B_HI = (PW+1)'(3 * 2**(PW-2));

  // Reject parameter sets the datapath widths cannot represent.
  if (N < 2 || N > 16 || PW < 3 || RD_LAT < 1 || RD_LAT > 3 ||
      STABLE_N < 1 || STABLE_N > 15 || MAX_ITER < 1 || MAX_ITER > 255 ||
      HYST < 0 || HYST >= 2**(PW-2)) begin : g_param_check
    $error("onn_phase_scan_ctrl: parameter out of supported range");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_UPD  = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic [CW-1:0]  r_cnt;
  logic [N-1:0]   r_cap;
  logic [N-1:0]   r_prev;
  logic [N-1:0]   r_state_vec;
  logic [N-1:0]   r_changed;
  logic [3:0]     r_stable;
  logic [7:0]     r_iter;
  logic           r_conv;
  logic           r_tmo;
  logic           r_done;

  logic [PW-1:0]  w_d;
  logic [PW:0]    w_dx;
  logic           w_plain;
  logic           w_bit;
  logic [IW-1:0]  w_idx;
  logic           w_cap_en;
  logic           w_same;
  logic [3:0]     w_stable_nxt;
  logic [7:0]     w_iter_nxt;
  logic           w_conv_hit;
  logic           w_tmo_hit;

  // Phase difference modulo 2^PW and plain quadrant decision.
  assign w_d     = phase_in - ref_phase;
  assign w_dx    = {1'b0, w_d};
  assign w_plain = (w_dx >= B_LO) && (w_dx < B_HI);

  // Capture slot: the bit selected RD_LAT cycles ago arrives now.
  assign w_idx    = IW'(r_cnt - C_LAT);
  assign w_cap_en = (r_state == S_SCAN) && (r_cnt >= C_LAT);

`ifdef PHASE_HYST_EN
  localparam logic [PW:0] LO_A = (PW+1)'(2**(PW-2) - HYST);
  localparam logic [PW:0] LO_B = (PW+1)'(2**(PW-2) + HYST);
  localparam logic [PW:0] HI_A = (PW+1)'(3 * 2**(PW-2) - HYST);
  localparam logic [PW:0] HI_B = (PW+1)'(3 * 2**(PW-2) + HYST);

  logic w_band;

  // Near either boundary the neuron keeps the bit from the previous iteration.
  assign w_band = ((w_dx >= LO_A) && (w_dx < LO_B)) ||
                  ((w_dx >= HI_A) && (w_dx < HI_B));
  assign w_bit  = w_band ? r_prev[w_idx] : w_plain;
`else
  assign w_bit  = w_plain;
`endif

  // Iteration bookkeeping evaluated for the UPD cycle.
  assign w_same       = (r_cap == r_prev);
  assign w_stable_nxt = w_same ? ((r_stable == 4'hF) ? 4'hF : r_stable + 4'd1) : 4'd0;
  assign w_iter_nxt   = (r_iter == 8'hFF) ? 8'hFF : r_iter + 8'd1;
  assign w_conv_hit   = (w_stable_nxt == 4'(STABLE_N));
  assign w_tmo_hit    = (w_iter_nxt == 8'(MAX_ITER)) && !w_conv_hit;

  // FSM state register.
  always_ff @(posedge sclk or negedge re_n) begin
    if (!re_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic plus mux select and busy.
  always_comb begin
    w_next    = r_state;
    busy      = 1'b0;
    phase_sel = 4'd0;
    case (r_state)
      S_IDLE: begin
        if (start && !clr && !r_conv && !r_tmo) w_next = S_SCAN;
      end
      S_SCAN: begin
        busy      = 1'b1;
        phase_sel = (r_cnt < C_NSEL) ? 4'(r_cnt) : 4'(N - 1);
        if (clr)                  w_next = S_IDLE;
        else if (r_cnt == C_LAST) w_next = S_UPD;
      end
      S_UPD: begin
        busy   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Scan counter: counts only inside SCAN and restarts from 0 for every scan.
  always_ff @(posedge sclk or negedge re_n) begin
    if (!re_n) begin
      r_cnt <= '0;
    end else if (clr || r_state != S_SCAN || r_cnt == C_LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Capture register: one bit per cycle once the read pipeline is primed.
  always_ff @(posedge sclk or negedge re_n) begin
    if (!re_n) begin
      r_cap <= '0;
    end else if (clr) begin
      r_cap <= '0;
    end else if (w_cap_en) begin
      r_cap[w_idx] <= w_bit;
    end
  end

  // Iteration update: publish the new state, history, counters and flags.
  always_ff @(posedge sclk or negedge re_n) begin
    if (!re_n) begin
      r_prev      <= '0;
      r_state_vec <= '0;
      r_changed   <= '0;
      r_stable    <= '0;
      r_iter      <= '0;
      r_conv      <= 1'b0;
      r_tmo       <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (clr) begin
        r_prev      <= '0;
        r_state_vec <= '0;
        r_changed   <= '0;
        r_stable    <= '0;
        r_iter      <= '0;
        r_conv      <= 1'b0;
        r_tmo       <= 1'b0;
      end else if (r_state == S_UPD) begin
        r_state_vec <= r_cap;
        r_changed   <= r_cap ^ r_prev;
        r_prev      <= r_cap;
        r_stable    <= w_stable_nxt;
        r_iter      <= w_iter_nxt;
        r_done      <= 1'b1;
        if (w_conv_hit) r_conv <= 1'b1;
        if (w_tmo_hit)  r_tmo  <= 1'b1;
      end
    end
  end

  assign state_vec     = r_state_vec;
  assign state_changed = r_changed;
  assign scan_done     = r_done;
  assign converged     = r_conv;
  assign timeout       = r_tmo;
  assign iter_cnt      = r_iter;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_onn_phase_scan_ctrl.sv
// tb_onn_phase_scan_ctrl: scoreboard bench for onn_phase_scan_ctrl.
// A behavioural phase mux answers phase_sel one cycle later. Each accepted
// scan pushes the expected outputs to exp_q; the monitor pops and compares
// on every scan_done pulse. MAX_ITER is reduced to 5 so timeout is reachable.
module tb_onn_phase_scan_ctrl;

  localparam int N    = 15;
  localparam int MAXI = 5;
  localparam int W    = 40;  // {state_vec, state_changed, iter_cnt, converged, timeout}
`ifdef PHASE_HYST_EN
  localparam bit HYST_ON = 1'b1;
`else
  localparam bit HYST_ON = 1'b0;
`endif

  logic         sclk;
  logic         re_n;
  logic         start;
  logic         clr;
  logic [7:0]   ref_phase;
  logic [7:0]   phase_in;
  logic [3:0]   phase_sel;
  logic         busy;
  logic [N-1:0] state_vec;
  logic [N-1:0] state_changed;
  logic         scan_done;
  logic         converged;
  logic         timeout;
  logic [7:0]   iter_cnt;
  logic [1:0]   dbg_state;

  onn_phase_scan_ctrl #(
    .N(N), .PW(8), .RD_LAT(1), .STABLE_N(3), .MAX_ITER(MAXI), .HYST(8)
  ) dut (
    .sclk(sclk), .re_n(re_n), .start(start), .clr(clr),
    .ref_phase(ref_phase), .phase_in(phase_in), .phase_sel(phase_sel),
    .busy(busy), .state_vec(state_vec), .state_changed(state_changed),
    .scan_done(scan_done), .converged(converged), .timeout(timeout),
    .iter_cnt(iter_cnt), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset block ----------------
  int cyc = 0;
  initial sclk = 1'b0;
  always #5 sclk = ~sclk;
  always @(posedge sclk) cyc++;

  // ---------------- phase mux model (1-cycle read latency) ----------------
  logic [7:0] phases [16];
  logic [3:0] sel_s = 4'd0;
  always @(negedge sclk) sel_s = phase_sel;
  always @(posedge sclk) begin
    #1;
    phase_in = phases[sel_s];
  end

  // ---------------- checking ----------------
  int n_total = 0;
  int n_bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [N-1:0] m_prev;
  logic [3:0]   m_stable;
  logic [7:0]   m_iter;
  logic         m_conv;
  logic         m_tmo;

  task automatic model_reset();
    m_prev = '0; m_stable = '0; m_iter = '0; m_conv = 1'b0; m_tmo = 1'b0;
  endtask

  function automatic logic exp_bit(input logic [7:0] ph, input logic [7:0] rf, input logic pb);
    logic [7:0] d;
    logic       b;
    d = ph - rf;
    b = (d >= 8'd64) && (d < 8'd192);
    if (HYST_ON && ((d >= 8'd56 && d < 8'd72) || (d >= 8'd184 && d < 8'd200))) b = pb;
    return b;
  endfunction

  task automatic model_scan(output logic [W-1:0] e);
    logic [N-1:0] cap;
    logic [3:0]   s;
    logic [7:0]   it;
    for (int i = 0; i < N; i++) cap[i] = exp_bit(phases[i], ref_phase, m_prev[i]);
    if (cap == m_prev) s = (m_stable == 4'd15) ? 4'd15 : m_stable + 4'd1;
    else               s = 4'd0;
    it = (m_iter == 8'd255) ? 8'd255 : m_iter + 8'd1;
    if (s == 4'd3)             m_conv = 1'b1;
    else if (it == 8'(MAXI))   m_tmo  = 1'b1;
    e = {cap, cap ^ m_prev, it, m_conv, m_tmo};
    m_prev = cap; m_stable = s; m_iter = it;
  endtask

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q [$];
  logic [W-1:0] mon_e;

  always @(negedge sclk) begin
    if (re_n && scan_done) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_scan_done", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check_eq("state_vec",     32'(state_vec),     32'(mon_e[39:25]));
        check_eq("state_changed", 32'(state_changed), 32'(mon_e[24:10]));
        check_eq("iter_cnt",      32'(iter_cnt),      32'(mon_e[9:2]));
        check_eq("converged",     32'(converged),     32'(mon_e[1]));
        check_eq("timeout",       32'(timeout),       32'(mon_e[0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic fill(input logic [7:0] v);
    for (int i = 0; i < 16; i++) phases[i] = v;
  endtask

  task automatic pulse_start(output int t0);
    @(negedge sclk);
    start = 1'b1;
    @(posedge sclk);
    #1;
    t0 = cyc;
    @(negedge sclk);
    start = 1'b0;
  endtask

  // One scan request; when converged/timeout is expected, start must be ignored.
  task automatic run_scan();
    logic [W-1:0] e;
    int t0;
    bit got;
    if (m_conv || m_tmo) begin
      pulse_start(t0);
      for (int i = 0; i < 3; i++) begin
        check_eq("busy_ignored", 32'(busy), 32'd0);
        @(negedge sclk);
      end
      return;
    end
    model_scan(e);
    exp_q.push_back(e);
    pulse_start(t0);
    check_eq("busy_scan", 32'(busy), 32'd1);
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (scan_done) begin
        got = 1'b1;
        break;
      end
      @(negedge sclk);
    end
    check_eq("scan_done_seen", 32'(got), 32'd1);
    if (got) check_eq("scan_latency", 32'(cyc - t0), 32'd17);
    else     exp_q.delete();
    @(negedge sclk);
  endtask

  task automatic do_clr();
    @(negedge sclk);
    clr = 1'b1;
    @(negedge sclk);
    clr = 1'b0;
    model_reset();
    check_eq("clr_iter",    32'(iter_cnt),      32'd0);
    check_eq("clr_timeout", 32'(timeout),       32'd0);
    check_eq("clr_conv",    32'(converged),     32'd0);
    check_eq("clr_vec",     32'(state_vec),     32'd0);
    check_eq("clr_chg",     32'(state_changed), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0] dlist [15];
    int t0;
    bit seen;
    dlist = '{8'd0, 8'd63, 8'd64, 8'd127, 8'd128, 8'd191, 8'd192, 8'd255,
              8'd56, 8'd71, 8'd184, 8'd199, 8'd32, 8'd100, 8'd220};
    re_n = 1'b0; start = 1'b0; clr = 1'b0; ref_phase = 8'd0; phase_in = 8'd0;
    fill(8'd0);
    model_reset();
    repeat (3) @(negedge sclk);
    check_eq("rst_vec",   32'(state_vec), 32'd0);
    check_eq("rst_iter",  32'(iter_cnt),  32'd0);
    check_eq("rst_busy",  32'(busy),      32'd0);
    check_eq("rst_sel",   32'(phase_sel), 32'd0);
    check_eq("rst_done",  32'(scan_done), 32'd0);
    check_eq("rst_flags", 32'({converged, timeout}), 32'd0);
    check_eq("rst_fsm",   32'(dbg_state), 32'd0);
    re_n = 1'b1;

    // All phases aligned with the reference.
    run_scan();

    // Neuron 4 in antiphase, then the identical scan again.
    phases[4] = 8'd128;
    run_scan();
    run_scan();

    // Constant pattern until convergence; the following start is ignored.
    do_clr();
    for (int i = 0; i < 16; i++) phases[i] = 8'($urandom_range(0, 255));
    phases[0] = 8'd128;
    repeat (5) run_scan();

    // Neuron 0 toggles every scan: timeout after MAX_ITER scans.
    do_clr();
    fill(8'd0);
    for (int k = 0; k < 5; k++) begin
      phases[0] = (k % 2 == 0) ? 8'd128 : 8'd0;
      run_scan();
    end
    run_scan();

    // Convergence and budget hit on the same update: converged wins.
    do_clr();
    fill(8'd0);
    phases[3] = 8'd128;
    run_scan();
    phases[5] = 8'd128;
    repeat (4) run_scan();

    // Binarisation boundaries with a non-zero reference.
    do_clr();
    ref_phase = 8'd37;
    for (int i = 0; i < N; i++) phases[i] = dlist[i] + 8'd37;
    run_scan();

    // Hysteresis window around the lower boundary on neuron 2.
    do_clr();
    ref_phase = 8'd0;
    fill(8'd0);
    phases[2] = 8'd128;
    run_scan();
    phases[2] = 8'd60;
    run_scan();
    phases[2] = 8'd55;
    run_scan();

    // Random phases and references.
    for (int r = 0; r < 2; r++) begin
      do_clr();
      for (int s = 0; s < 4; s++) begin
        ref_phase = 8'($urandom_range(0, 255));
        for (int i = 0; i < 16; i++) phases[i] = 8'($urandom_range(0, 255));
        run_scan();
      end
    end

    // Asynchronous reset in the middle of a scan.
    do_clr();
    ref_phase = 8'd0;
    for (int i = 0; i < 16; i++) phases[i] = 8'($urandom_range(0, 255));
    phases[0] = 8'd128;
    pulse_start(t0);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (busy && phase_sel == 4'd7) begin
        seen = 1'b1;
        break;
      end
      @(negedge sclk);
    end
    check_eq("sel7_seen", 32'(seen), 32'd1);
    re_n = 1'b0;
    #1;
    check_eq("midrst_sel",  32'(phase_sel), 32'd0);
    check_eq("midrst_busy", 32'(busy),      32'd0);
    check_eq("midrst_vec",  32'(state_vec), 32'd0);
    check_eq("midrst_fsm",  32'(dbg_state), 32'd0);
    exp_q.delete();
    model_reset();
    @(negedge sclk);
    re_n = 1'b1;
    run_scan();

    repeat (3) @(negedge sclk);
    check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/onn_phase_scan_ctrl.md
Name: onn_phase_scan_ctrl

Overview:
- Scan scheduler for the 3x5 ONN: time-shares one phase-read mux across all N neurons and binarises each phase against a reference oscillator.
- Assembles the N-bit network state and compares it with the previous iteration. Drives the state_changed vector consumed by control_fsm.
- Tracks stable iterations to flag convergence, and flags timeout when the iteration budget is exhausted.
- Triggered once per annealing iteration by control_fsm's state_cheak pulse.

Parameters:
- N, 15, number of neurons (3x5 array); width of all state vectors.
- PW, 8, phase word width.
- RD_LAT, 1, cycles from phase_sel change to valid phase_in (1..3).
- STABLE_N, 3, consecutive unchanged scans required for convergence (1..15).
- MAX_ITER, 255, scan budget before timeout (fits 8 bits).
- HYST, 8, guard band in phase LSBs; used only with PHASE_HYST_EN.

Ports:
- sclk  in  1  system clock, all state on rising edge.
- re_n  in  1  asynchronous active-low reset.
- start  in  1  request one scan (connect state_cheak); sampled only in IDLE.
- clr  in  1  synchronous clear of history, counters and sticky flags; priority over start.
- ref_phase  in  PW  reference oscillator phase.
- phase_in  in  PW  phase of the neuron selected by phase_sel, valid RD_LAT cycles after select.
- phase_sel  out  4  neuron index driven to the phase mux.
- busy  out  1  high in SCAN and UPD.
- state_vec  out  N  binarised state from the last completed scan.
- state_changed  out  N  state_vec XOR previous state_vec.
- scan_done  out  1  one-cycle pulse when the outputs above update.
- converged  out  1  sticky; set when stable count reaches STABLE_N.
- timeout  out  1  sticky; set when iter_cnt reaches MAX_ITER without convergence.
- iter_cnt  out  8  completed scans since reset/clr; saturates at 255.

Behaviour:
- Reset (re_n low, any time including mid-scan): immediately returns to IDLE. All outputs 0, phase_sel 0, internal prev vector, stable count and capture register 0.
- States: IDLE, SCAN, UPD.
- IDLE -> SCAN when start=1, clr=0, converged=0 and timeout=0. Otherwise start is ignored; start during busy is also ignored, never queued.
- SCAN, counter c = 0..N+RD_LAT-1:
  - phase_sel = c for c < N; holds N-1 afterwards.
  - At c >= RD_LAT, bit (c-RD_LAT) of the capture register is loaded.
  - Exits to UPD after c = N+RD_LAT-1.
- Binarisation, computed modulo 2^PW:
  - d = phase_in - ref_phase.
  - bit = 1 (antiphase) if 2^(PW-2) <= d < 3*2^(PW-2), else 0 (in-phase).
  - Boundary values: d = 64 -> 1, d = 192 -> 0 (PW=8).
- UPD, single cycle, then IDLE:
  - state_vec <= capture; state_changed <= capture ^ prev; prev <= capture.
  - iter_cnt increments, saturating at 255.
  - Stable count: increments (saturating) if capture == prev, else clears to 0.
  - converged set when the new stable count == STABLE_N.
  - timeout set when the new iter_cnt == MAX_ITER and converged is not set in the same update; converged wins on simultaneous hit.
- scan_done is high in the cycle after UPD. Latency: start accepted at edge 0 -> scan_done high after edge N+RD_LAT+1 (17 cycles for the defaults).
- First scan after reset/clr: prev = 0, so state_changed = state_vec.
- clr in IDLE: zeroes prev, stable count, iter_cnt, state_vec, state_changed, converged, timeout.
- clr during SCAN/UPD: aborts to IDLE with the same clearing; no scan_done pulse.
- Changing ref_phase mid-scan is allowed; each bit uses ref_phase at its own capture cycle.

Optional Feature:
- Macro: PHASE_HYST_EN.
- When defined, a neuron's bit keeps its prev value if d lies within HYST of either decision boundary. Boundaries are 2^(PW-2) and 3*2^(PW-2); band is boundary-HYST <= d < boundary+HYST. Outside the band the normal rule applies.
- When undefined, plain quadrant thresholding with no memory; HYST unused.

Test Plan:
- Reset then start with ref_phase=0, all phase_in=0 -> scan_done 17 cycles after start; state_vec=0, state_changed=0, iter_cnt=1.
- Neuron 4 phase 128, others 0, ref=0, first scan -> state_vec=15'h0010, state_changed=15'h0010. Repeat the scan -> state_changed=0.
- Identical phases for 4 consecutive scans -> converged rises at the scan_done of scan 4 (stable count 3). A further start is ignored and busy stays 0.
- MAX_ITER=5 with neuron 0 toggling 0/128 each scan -> timeout=1 at scan_done of scan 5, converged=0. clr -> timeout=0, iter_cnt=0.
- re_n low at SCAN c=7 -> phase_sel, busy, state_vec immediately 0; next start yields a full 17-cycle scan with state_changed = state_vec.
- PHASE_HYST_EN, HYST=8: neuron 2 at 60 after a prior bit 1 -> bit stays 1; at 55 -> bit 0. Without the macro, 60 -> 0.
